// File: rtl/univ_bin_counter_pkg.sv
// Shared constants and helpers for the universal binary counter.
// Optional feature macro used by the counter: UNIV_BIN_COUNTER_SATURATE_EN
// (defined: count saturates at the ends; undefined: count wraps modulo 2^N).
package univ_bin_counter_pkg;

  // Default counter width when the parameter is not overridden.
  localparam int unsigned UBC_DEFAULT_N = 8;

  // Largest value representable in n bits (2^n - 1), valid for n = 1..32.
  function automatic logic [31:0] ubc_max(input int unsigned n);
    logic [63:0] full;
    full = (64'd1 << n) - 64'd1;
    return full[31:0];
  endfunction

endpackage

// File: rtl/univ_bin_counter_next_state.sv
// Combinational next-count selection for the universal binary counter.
// Priority: synchronous clear, then parallel load, then count up/down, else hold.
// Macro UNIV_BIN_COUNTER_SATURATE_EN: when defined, counting holds at the
// end points instead of wrapping; clear and load are unaffected.
module ubc_next_state
  import univ_bin_counter_pkg::*;
#(
  parameter int unsigned N = UBC_DEFAULT_N
) (
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  input  logic [N-1:0] q,
  output logic [N-1:0] q_next
);

  localparam logic [N-1:0] Q_MAX = N'(ubc_max(N));
  localparam logic [N-1:0] Q_ONE = N'(1);

  logic at_max;
  logic at_min;

  assign at_max = (q == Q_MAX);
  assign at_min = (q == '0);

  // Select the value the register takes on the next rising edge.
  always_comb begin
    q_next = q;
    if (syn_clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = d;
    end else if (en) begin
      if (up) begin
`ifdef UNIV_BIN_COUNTER_SATURATE_EN
        q_next = at_max ? q : q + Q_ONE;
`else
        q_next = q + Q_ONE;
`endif
      end else begin
`ifdef UNIV_BIN_COUNTER_SATURATE_EN
        q_next = at_min ? q : q - Q_ONE;
`else
        q_next = q - Q_ONE;
`endif
      end
    end
  end

`ifndef UNIV_BIN_COUNTER_SATURATE_EN
  // End-point decodes only matter when saturating; keep them visibly used.
  logic unused_ends;
  assign unused_ends = at_max ^ at_min;
`endif

endmodule

// File: rtl/univ_bin_counter.sv
// Parameterised N-bit universal binary counter: async active-low reset,
// synchronous clear, parallel load, enable and up/down direction, with
// combinational terminal-count flags decoded straight from the count.
// Macro UNIV_BIN_COUNTER_SATURATE_EN selects saturating instead of wrapping count.
module univ_bin_counter
  import univ_bin_counter_pkg::*;
#(
  parameter int unsigned N = UBC_DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic         max_tick,
  output logic         min_tick,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] Q_MAX = N'(ubc_max(N));

  logic [N-1:0] q_reg;
  logic [N-1:0] q_next;

  ubc_next_state #(
    .N(N)
  ) u_next_state (
    .syn_clr(syn_clr),
    .load   (load),
    .en     (en),
    .up     (up),
    .d      (d),
    .q      (q_reg),
    .q_next (q_next)
  );

  // Count register; reset clears it immediately, independent of the clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q        = q_reg;
  assign max_tick = (q_reg == Q_MAX);
  assign min_tick = (q_reg == '0);

endmodule

// File: tb/tb_univ_bin_counter.sv
// Self-checking bench for univ_bin_counter at N=3: directed steps followed by
// random control traffic, all checked against an arithmetic reference model.
module tb_univ_bin_counter;

  localparam int N    = 3;
  localparam int MODV = 8;

  logic         clk;
  logic         reset;
  logic         syn_clr;
  logic         load;
  logic         en;
  logic         up;
  logic [N-1:0] d;
  logic         max_tick;
  logic         min_tick;
  logic [N-1:0] q;

  int checks = 0;
  int errors = 0;
  int model_q = 0;

  univ_bin_counter #(
    .N(N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .syn_clr (syn_clr),
    .load    (load),
    .en      (en),
    .up      (up),
    .d       (d),
    .max_tick(max_tick),
    .min_tick(min_tick),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour from the counter's rules, in plain integer arithmetic.
  function automatic int model_next(int cur, bit sc, bit ld, bit e, bit u, int dv);
    int nq;
    if (sc) return 0;
    if (ld) return dv;
    if (!e) return cur;
    nq = u ? cur + 1 : cur - 1;
`ifdef UNIV_BIN_COUNTER_SATURATE_EN
    if (nq > MODV - 1) nq = MODV - 1;
    if (nq < 0) nq = 0;
`else
    nq = (nq + MODV) % MODV;
`endif
    return nq;
  endfunction

  task automatic check_all(input string tag);
    logic [N-1:0] exp_q;
    logic         exp_max;
    logic         exp_min;
    exp_q   = N'(model_q);
    exp_max = (model_q == MODV - 1);
    exp_min = (model_q == 0);
    checks++;
    assert (q === exp_q) else begin
      errors++;
      $error("FAIL %s q got %0d expected %0d", tag, q, exp_q);
    end
    checks++;
    assert (max_tick === exp_max) else begin
      errors++;
      $error("FAIL %s max_tick got %0b expected %0b", tag, max_tick, exp_max);
    end
    checks++;
    assert (min_tick === exp_min) else begin
      errors++;
      $error("FAIL %s min_tick got %0b expected %0b", tag, min_tick, exp_min);
    end
    $display("%0t %-10s sc=%0b ld=%0b en=%0b up=%0b d=%0d -> q=%0d max=%0b min=%0b",
             $time, tag, syn_clr, load, en, up, d, q, max_tick, min_tick);
  endtask

  // Apply one set of controls for one rising edge, then check 1 time unit later.
  task automatic cycle(input string tag, input bit sc, input bit ld, input bit e,
                       input bit u, input int dv);
    syn_clr = sc;
    load    = ld;
    en      = e;
    up      = u;
    d       = N'(dv);
    model_q = model_next(model_q, sc, ld, e, u, dv);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset   = 1'b0;
    syn_clr = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    up      = 1'b0;
    d       = '0;
    model_q = 0;

    // Reset state, held across an edge.
    @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // Load 5, then drop reset mid-cycle: q must clear without a clock edge.
    cycle("load5", 0, 1, 0, 0, 5);
    #2;
    reset   = 1'b0;
    model_q = 0;
    #1;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    cycle("rel_idle", 0, 0, 0, 0, 0);
    cycle("rel_idle", 0, 0, 0, 0, 0);

    // Load, hold, clear.
    cycle("load3", 0, 1, 0, 0, 3);
    cycle("hold", 0, 0, 0, 0, 0);
    cycle("hold", 0, 0, 0, 0, 0);
    cycle("clr", 1, 0, 0, 0, 0);

    // Count up ten edges through the top end.
    for (int i = 0; i < 10; i++) cycle("up", 0, 0, 1, 1, 0);

    // Hold, then count down from 4 through the bottom end.
    cycle("en_off", 0, 0, 0, 1, 0);
    cycle("en_off", 0, 0, 0, 0, 0);
    cycle("load4", 0, 1, 0, 0, 4);
    for (int i = 0; i < 5; i++) cycle("down", 0, 0, 1, 0, 0);

    // Priority: clear beats load and enable; load beats enable.
    cycle("prio_clr", 1, 1, 1, 1, 6);
    cycle("prio_ld", 0, 1, 1, 1, 6);

    // End-point behaviour (wraps by default, holds when saturating).
    for (int i = 0; i < 3; i++) cycle("up_end", 0, 0, 1, 1, 0);
    cycle("load1", 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle("dn_end", 0, 0, 1, 0, 0);

    // Random control traffic, with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      bit rsc;
      bit rld;
      bit ren;
      bit rup;
      int rdv;
      rsc = ($urandom_range(0, 15) == 0);
      rld = ($urandom_range(0, 7) == 0);
      ren = ($urandom_range(0, 3) != 0);
      rup = $urandom_range(0, 1) == 1;
      rdv = $urandom_range(0, MODV - 1);
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        reset   = 1'b0;
        model_q = 0;
        #1;
        check_all("rnd_rst");
        #1;
        reset = 1'b1;
      end
      cycle("rnd", rsc, rld, ren, rup, rdv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_bin_counter.md
Name: univ_bin_counter

Overview:
- Parameterised N-bit universal binary counter with async reset, sync clear, parallel load, enable and up/down direction.
- Drives its current count plus terminal-count flags (max_tick, min_tick).
- Generic building block for timers, address generators and sequencers.

Parameters:
- N, 8: counter width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-low; clears q to 0.
- syn_clr  input  1  synchronous clear, active-high.
- load  input  1  synchronous parallel load, active-high.
- en  input  1  count enable, active-high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- d  input  N  parallel load value.
- max_tick  output  1  high when q == 2^N-1.
- min_tick  output  1  high when q == 0.
- q  output  N  current count, registered.

Behaviour:
- State: one N-bit register q; all updates on rising clk edge.
- Reset: reset low forces q=0 immediately, independent of clk.
  - Outputs while in reset: q=0, min_tick=1, max_tick=0.
  - Deassertion is synchronised externally. The first edge after release obeys normal priority.
- Priority per edge, highest first:
  - syn_clr=1 -> q<=0.
  - load=1 -> q<=d.
  - en=1 and up=1 -> q<=q+1 modulo 2^N.
  - en=1 and up=0 -> q<=q-1 modulo 2^N.
  - otherwise -> q holds.
- Simultaneous controls: syn_clr beats load and en; load beats en. up is ignored unless counting.
- Wrap-around (default build): 2^N-1 +1 -> 0; 0 -1 -> 2^N-1.
- Ticks: purely combinational decodes of q, not qualified by en or up, no latency. Both are asserted together only when N... never (N>=1).
- Latency: one clock from a control input to the q update; ticks follow q in the same cycle.
- No X-propagation on q after reset; d is sampled only when load=1 and syn_clr=0.

Optional Feature:
- Macro: UNIV_BIN_COUNTER_SATURATE_EN.
- Defined:
  - Counting up at q=2^N-1 holds at 2^N-1.
  - Counting down at q=0 holds at 0.
  - syn_clr and load are unaffected.
- Undefined: modulo wrap-around as specified above.

Decomposition:
- Package univ_bin_counter_pkg:
  - UBC_DEFAULT_N = 8.
  - Function ubc_max(N) returning 2^N-1.
- Optional sub-module ubc_next_state: combinational next-q mux implementing the priority and wrap/saturate rule.
- Top level holds the register and the tick decodes.

Test Plan (N=3):
- Reset low mid-count at q=5 -> q=0 asynchronously, min_tick=1; after release with all controls low, q stays 0.
- load=1, d=3 for one edge -> q=3. Two idle edges -> q stays 3. syn_clr one edge -> q=0.
- en=1, up=1 from 0 for 10 edges -> q goes 1..7,0,1,2. max_tick=1 only while q=7; wraps 7->0.
- en=0 for 2 edges -> q holds. en=1, up=0 from 4 -> 3,2,1,0,7. min_tick=1 at q=0; wraps 0->7.
- syn_clr=1, load=1, en=1, d=6 on the same edge -> q=0. load=1, en=1, up=1, d=6 -> q=6.
- UNIV_BIN_COUNTER_SATURATE_EN defined:
  - up from 6 for 3 edges -> 7,7,7.
  - down from 1 for 3 edges -> 0,0,0.
